array_rr_scheduler: RTL



---
 rtl/array_rr_scheduler_pkg.sv | 17 +
 rtl/array_rr_scheduler.sv | 138 +++++++++++++
 2 files changed

// File: rtl/array_rr_scheduler_pkg.sv
// Shared types for the array round-robin scheduler.
//   int_5          : one array word, five 32-bit two's-complement integers
//   sched_state_t  : POLL0 / POLL1 / SEND
//   CNT_W_DEFAULT  : default width of the per-source transfer counters
package array_sched_types;

  typedef logic signed [0:4][31:0] int_5;

  typedef enum logic [1:0] {
    POLL0 = 2'd0,
    POLL1 = 2'd1,
    SEND  = 2'd2
  } sched_state_t;

  localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/array_rr_scheduler.sv
// array_rr_scheduler
// Shares one int_5 consumer port between two array producers. The block
// polls requester 0 and 1 alternately, captures one array from the polled
// requester when it is valid, forwards it tagged with its source, and then
// hands the next poll to the other requester (round-robin after every grant).
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   reqK_in               : array from requester K (K = 0/1)
//   reqK_in_sync          : requester K has valid data
//   reqK_in_notify        : block is polling requester K (registered)
//   arr_out, arr_out_src  : forwarded array and its source index
//   arr_out_sync          : consumer ready
//   arr_out_notify        : arr_out/arr_out_src valid (registered)
//   cnt0, cnt1            : wrapping count of arrays forwarded per source
module array_rr_scheduler
  import array_sched_types::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  int_5             req0_in,
  input  logic             req0_in_sync,
  output logic             req0_in_notify,
  input  int_5             req1_in,
  input  logic             req1_in_sync,
  output logic             req1_in_notify,
  output int_5             arr_out,
  output logic             arr_out_src,
  input  logic             arr_out_sync,
  output logic             arr_out_notify,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  sched_state_t     state_q, state_d;
  logic             req0_notify_q, req0_notify_d;
  logic             req1_notify_q, req1_notify_d;
  logic             out_notify_q, out_notify_d;
  int_5             arr_q, arr_d;
  logic             src_q, src_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // The notifies are registered copies of the next state decode, so at most
  // one of them is ever high. Only the polled requester's sync is looked at.
  always_comb begin
    state_d       = state_q;
    req0_notify_d = req0_notify_q;
    req1_notify_d = req1_notify_q;
    out_notify_d  = out_notify_q;
    arr_d         = arr_q;
    src_d         = src_q;
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;

    case (state_q)
      POLL0: begin
        req0_notify_d = 1'b0;
        if (req0_notify_q && req0_in_sync) begin
          arr_d        = req0_in;
          src_d        = 1'b0;
          out_notify_d = 1'b1;
          state_d      = SEND;
        end else begin
          req1_notify_d = 1'b1;
          state_d       = POLL1;
        end
      end
      POLL1: begin
        req1_notify_d = 1'b0;
        if (req1_notify_q && req1_in_sync) begin
          arr_d        = req1_in;
          src_d        = 1'b1;
          out_notify_d = 1'b1;
          state_d      = SEND;
        end else begin
          req0_notify_d = 1'b1;
          state_d       = POLL0;
        end
      end
      SEND: begin
        if (out_notify_q && arr_out_sync) begin
          out_notify_d = 1'b0;
          // Next poll goes to the requester that was not just served.
          if (src_q) begin
            cnt1_d        = cnt1_q + 1'b1;
            req0_notify_d = 1'b1;
            state_d       = POLL0;
          end else begin
            cnt0_d        = cnt0_q + 1'b1;
            req1_notify_d = 1'b1;
            state_d       = POLL1;
          end
        end
      end
      default: begin
        state_d       = POLL0;
        req0_notify_d = 1'b1;
        req1_notify_d = 1'b0;
        out_notify_d  = 1'b0;
      end
    endcase
  end

  // State register stage: reset drops any pending array and restarts at POLL0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= POLL0;
      req0_notify_q <= 1'b1;
      req1_notify_q <= 1'b0;
      out_notify_q  <= 1'b0;
      arr_q         <= '{default: '0};
      src_q         <= 1'b0;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
    end else begin
      state_q       <= state_d;
      req0_notify_q <= req0_notify_d;
      req1_notify_q <= req1_notify_d;
      out_notify_q  <= out_notify_d;
      arr_q         <= arr_d;
      src_q         <= src_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
    end
  end

  assign req0_in_notify = req0_notify_q;
  assign req1_in_notify = req1_notify_q;
  assign arr_out_notify = out_notify_q;
  assign arr_out        = arr_q;
  assign arr_out_src    = src_q;
  assign cnt0           = cnt0_q;
  assign cnt1           = cnt1_q;

endmodule
